// File: rtl/chip_bus_sequencer.sv
// Sequencer for the shared 8-bit sound-chip bus (2x YM2203 + SAA1099).
// In-order request FIFO, programmable setup/strobe/hold timing and per-chip recovery gaps.
module chip_bus_sequencer #(
  parameter int unsigned FIFO_LOG2  = 2,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned YM_AWAIT   = 24,
  parameter int unsigned YM_DWAIT   = 96,
  parameter int unsigned SAA_WAIT   = 8
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_tgt,
  input  logic       req_a0,
  input  logic       req_rd,
  input  logic [7:0] req_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       ymcs1_n,
  output logic       ymcs2_n,
  output logic       ymrd_n,
  output logic       ymwr_n,
  output logic       yma0,
  output logic       saacs_n,
  output logic       saawr_n,
  output logic       saaa0,
  output logic       busy
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned CW    = FIFO_LOG2 + 1;
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef struct packed {
    logic [1:0] tgt;
    logic       a0;
    logic       rd;
    logic [7:0] data;
  } entry_t;

  // Request FIFO
  entry_t                 fifo_q [DEPTH];
  logic [FIFO_LOG2-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   ready_q;
  logic                   push, pop;
  entry_t                 head, req_entry;

  assign req_entry = {req_tgt, req_a0, req_rd, req_data};
  assign head      = fifo_q[rptr_q];
  assign push      = req_valid && ready_q;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge fclk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_LOG2'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_LOG2'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge fclk) begin
    if (push) fifo_q[wptr_q] <= req_entry;
  end

  // Sequencer FSM
  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  entry_t     cur_q, cur_d;
  logic       imm_rd;
  logic       gap_load;
  logic [7:0] gap_val;
  logic [7:0] head_gap;
  logic [7:0] gap_q [3];

  always_comb begin
    head_gap = '0;
    case (head.tgt)
      2'd0:    head_gap = gap_q[0];
      2'd1:    head_gap = gap_q[1];
      default: head_gap = gap_q[2];
    endcase
  end

  always_comb begin
    gap_val = '0;
    if (cur_q.tgt == 2'd2)  gap_val = 8'(SAA_WAIT);
    else if (cur_q.rd)      gap_val = '0;
    else if (cur_q.a0)      gap_val = 8'(YM_DWAIT);
    else                    gap_val = 8'(YM_AWAIT);
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cur_d    = cur_q;
    pop      = 1'b0;
    imm_rd   = 1'b0;
    gap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          // Reserved target and SAA reads complete without touching the bus
          if (head.tgt == 2'd3 || (head.tgt == 2'd2 && head.rd)) begin
            pop    = 1'b1;
            imm_rd = head.rd;
          end else if (head_gap == '0) begin
            pop     = 1'b1;
            cur_d   = head;
            state_d = SETUP;
            phase_d = '0;
          end
        end
      end
      SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = STROBE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      STROBE: begin
        if (phase_q == STROBE_LAST) begin
          state_d = HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_d  = IDLE;
          phase_d  = '0;
          gap_load = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge fclk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (rst)                                    gap_q[i] <= '0;
      else if (gap_load && cur_q.tgt == 2'(i))    gap_q[i] <= gap_val;
      else if (gap_q[i] != '0)                    gap_q[i] <= gap_q[i] - 8'd1;
    end
  end

  // Bus outputs trail state_q by one register stage; the read sample is taken
  // as state_q enters HOLD, which is the last visible STROBE cycle.
  logic       act, strb, is_ym, rd_sample;
  logic       ymcs1_n_d, ymcs2_n_d, ymrd_n_d, ymwr_n_d, yma0_d;
  logic       saacs_n_d, saawr_n_d, saaa0_d, d_oe_d, rd_valid_d, busy_d;
  logic [7:0] d_out_d, rd_data_d;
  logic       ymcs1_n_q, ymcs2_n_q, ymrd_n_q, ymwr_n_q, yma0_q;
  logic       saacs_n_q, saawr_n_q, saaa0_q, d_oe_q, rd_valid_q, busy_q;
  logic [7:0] d_out_q, rd_data_q;

  always_comb begin
    act        = (state_q != IDLE);
    strb       = (state_q == STROBE);
    is_ym      = (cur_q.tgt != 2'd2);
    rd_sample  = (state_q == HOLD) && (phase_q == '0) && cur_q.rd;
    ymcs1_n_d  = !(act && cur_q.tgt == 2'd0);
    ymcs2_n_d  = !(act && cur_q.tgt == 2'd1);
    saacs_n_d  = !(act && cur_q.tgt == 2'd2);
    ymwr_n_d   = !(strb && is_ym && !cur_q.rd);
    ymrd_n_d   = !(strb && is_ym && cur_q.rd);
    saawr_n_d  = !(strb && !is_ym);
    yma0_d     = act && is_ym && cur_q.a0;
    saaa0_d    = act && !is_ym && cur_q.a0;
    d_oe_d     = act && !cur_q.rd;
    d_out_d    = d_oe_d ? cur_q.data : '0;
    rd_valid_d = imm_rd || rd_sample;
    rd_data_d  = rd_data_q;
    if (imm_rd)         rd_data_d = 8'hFF;
    else if (rd_sample) rd_data_d = d_in;
    busy_d     = act || (count_q != '0) ||
                 (gap_q[0] != '0) || (gap_q[1] != '0) || (gap_q[2] != '0);
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      ymcs1_n_q  <= 1'b1;
      ymcs2_n_q  <= 1'b1;
      ymrd_n_q   <= 1'b1;
      ymwr_n_q   <= 1'b1;
      yma0_q     <= 1'b0;
      saacs_n_q  <= 1'b1;
      saawr_n_q  <= 1'b1;
      saaa0_q    <= 1'b0;
      d_oe_q     <= 1'b0;
      d_out_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'hFF;
      busy_q     <= 1'b0;
    end else begin
      ymcs1_n_q  <= ymcs1_n_d;
      ymcs2_n_q  <= ymcs2_n_d;
      ymrd_n_q   <= ymrd_n_d;
      ymwr_n_q   <= ymwr_n_d;
      yma0_q     <= yma0_d;
      saacs_n_q  <= saacs_n_d;
      saawr_n_q  <= saawr_n_d;
      saaa0_q    <= saaa0_d;
      d_oe_q     <= d_oe_d;
      d_out_q    <= d_out_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign ymcs1_n   = ymcs1_n_q;
  assign ymcs2_n   = ymcs2_n_q;
  assign ymrd_n    = ymrd_n_q;
  assign ymwr_n    = ymwr_n_q;
  assign yma0      = yma0_q;
  assign saacs_n   = saacs_n_q;
  assign saawr_n   = saawr_n_q;
  assign saaa0     = saaa0_q;
  assign d_oe      = d_oe_q;
  assign d_out     = d_out_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;

endmodule
